// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder controller.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/sheffer.sv
// Two-input NAND (Sheffer stroke) primitive used to build the shared full adder.
module sheffer (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a & b);
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one NAND-built full adder time-shared LSB-first across WIDTH bits,
// with valid/ready handshakes on operands and result.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  io
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             c_msb_q, c_msb_d;
    logic             cout_q, cout_d;

    logic n1, n2, n3, hs, n5, n6, n7, fa_s, fa_co;
    logic last_bit;

    // Shared full adder: half-sum a^b, then sum and carry, all in NAND.
    sheffer u_n1 (.a(a_q[0]), .b(b_q[0]), .y(n1));
    sheffer u_n2 (.a(a_q[0]), .b(n1),     .y(n2));
    sheffer u_n3 (.a(b_q[0]), .b(n1),     .y(n3));
    sheffer u_hs (.a(n2),     .b(n3),     .y(hs));
    sheffer u_n5 (.a(hs),     .b(carry_q), .y(n5));
    sheffer u_n6 (.a(hs),     .b(n5),     .y(n6));
    sheffer u_n7 (.a(carry_q), .b(n5),    .y(n7));
    sheffer u_s  (.a(n6),     .b(n7),     .y(fa_s));
    sheffer u_co (.a(n5),     .b(n1),     .y(fa_co));

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        c_msb_d = c_msb_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    a_d     = io.a;
                    b_d     = io.b;
                    carry_d = io.cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Result fills from the MSB end so bit i lands in place after WIDTH shifts.
                sum_d   = (sum_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (last_bit) begin
                    c_msb_d = carry_q;
                    cout_d  = fa_co;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (io.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            c_msb_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            c_msb_q <= c_msb_d;
            cout_q  <= cout_d;
        end
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = (state_q == DONE);
    assign io.sum       = sum_q;
    assign io.cout      = cout_q;
    assign io.ovf       = c_msb_q ^ cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: WIDTH=8 and WIDTH=1 instances, scoreboarded results.
module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) if8 ();
    serial_adder_if #(.WIDTH(1)) if1 ();

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .io(if8));
    serial_adder_ctrl #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .io(if1));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } res8_t;

    typedef struct packed {
        logic sum;
        logic cout;
        logic ovf;
    } res1_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    res8_t sb8[$];
    res1_t sb1[$];
    res8_t e8;
    res1_t e1;
    vec_t  vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard pop on each output handshake (sampled on the falling edge).
    always @(negedge clk) begin
        if (rst_n) begin
            if (if8.in_ready && if8.out_valid)
                check("w8_ready_valid_overlap", 32'd1, 32'd0);
            if (if8.out_valid && if8.out_ready) begin
                if (sb8.size() == 0) begin
                    check("w8_stale_out_valid", 32'd1, 32'd0);
                end else begin
                    e8 = sb8.pop_front();
                    check("w8_sum",  32'(if8.sum),  32'(e8.sum));
                    check("w8_cout", 32'(if8.cout), 32'(e8.cout));
                    check("w8_ovf",  32'(if8.ovf),  32'(e8.ovf));
                end
            end
            if (if1.out_valid && if1.out_ready) begin
                if (sb1.size() == 0) begin
                    check("w1_stale_out_valid", 32'd1, 32'd0);
                end else begin
                    e1 = sb1.pop_front();
                    check("w1_sum",  32'(if1.sum),  32'(e1.sum));
                    check("w1_cout", 32'(if1.cout), 32'(e1.cout));
                    check("w1_ovf",  32'(if1.ovf),  32'(e1.ovf));
                end
            end
        end
    end

    // Called at a falling edge; returns at the falling edge where out_valid is first seen.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input res8_t exp_r);
        int k;
        int lat;
        k = 0;
        while (!if8.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!if8.in_ready) begin
            check("w8_in_ready_timeout", 32'(if8.in_ready), 32'd1);
            return;
        end
        if8.a = a; if8.b = b; if8.cin = c; if8.in_valid = 1'b1;
        sb8.push_back(exp_r);
        @(posedge clk);
        #1 if8.in_valid = 1'b0;
        lat = 0;
        for (int j = 1; j <= 40; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (if8.out_valid) begin
                lat = j;
                break;
            end
        end
        check("w8_latency", 32'(lat), 32'd8);
    endtask

    task automatic op1(input logic a, input logic b, input logic c, input res1_t exp_r);
        int k;
        int lat;
        k = 0;
        while (!if1.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!if1.in_ready) begin
            check("w1_in_ready_timeout", 32'(if1.in_ready), 32'd1);
            return;
        end
        if1.a = a; if1.b = b; if1.cin = c; if1.in_valid = 1'b1;
        sb1.push_back(exp_r);
        @(posedge clk);
        #1 if1.in_valid = 1'b0;
        lat = 0;
        for (int j = 1; j <= 20; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (if1.out_valid) begin
                lat = j;
                break;
            end
        end
        check("w1_latency", 32'(lat), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] s9;
        logic       xa, xb, xc, xs, xco;

        vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[3] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};
        vecs[5] = '{8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0};

        rst_n = 1'b0;
        if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0; if8.out_ready = 1'b1;
        if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0; if1.out_ready = 1'b1;

        // Reset state, with a request pending that must not be registered.
        #1;
        if8.in_valid = 1'b1; if8.a = 8'h11; if8.b = 8'h22;
        check("rst_in_ready",  32'(if8.in_ready),  32'd1);
        check("rst_out_valid", 32'(if8.out_valid), 32'd0);
        check("rst_sum",       32'(if8.sum),       32'd0);
        check("rst_cout",      32'(if8.cout),      32'd0);
        check("rst_ovf",       32'(if8.ovf),       32'd0);
        check("rst_w1_sum",    32'(if1.sum),       32'd0);
        repeat (3) @(posedge clk);
        #1 if8.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_no_transfer_in_ready", 32'(if8.in_ready), 32'd1);

        // Table-driven vectors.
        for (int i = 0; i < 6; i++)
            op8(vecs[i].a, vecs[i].b, vecs[i].cin, res8_t'({vecs[i].sum, vecs[i].cout, vecs[i].ovf}));

        // Random operands against an arithmetic model.
        for (int i = 0; i < 10; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            s9 = 9'(ra) + 9'(rb) + 9'(rc);
            op8(ra, rb, rc, res8_t'({s9[7:0], s9[8], (ra[7] == rb[7]) && (s9[7] != ra[7])}));
        end

        // Back-to-back: second op accepted one edge after the first handshake.
        @(negedge clk);
        op8(8'hFF, 8'h00, 1'b1, res8_t'({8'h00, 1'b1, 1'b0}));
        check("b2b_in_ready_in_done", 32'(if8.in_ready), 32'd0);
        @(negedge clk);
        check("b2b_in_ready_after_hs", 32'(if8.in_ready), 32'd1);
        op8(8'h7F, 8'h01, 1'b0, res8_t'({8'h80, 1'b0, 1'b1}));

        // Backpressure: DONE held with new operands offered.
        @(posedge clk);
        #1 if8.out_ready = 1'b0;
        @(negedge clk);
        op8(8'h80, 8'h80, 1'b0, res8_t'({8'h00, 1'b1, 1'b1}));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if8.in_valid = ~if8.in_valid;
            if8.a = 8'(17 * (i + 1));
            if8.b = 8'(3 * (i + 1));
            @(negedge clk);
            check("bp_out_valid", 32'(if8.out_valid), 32'd1);
            check("bp_in_ready",  32'(if8.in_ready),  32'd0);
            check("bp_sum",       32'(if8.sum),       32'h00);
            check("bp_cout",      32'(if8.cout),      32'd1);
            check("bp_ovf",       32'(if8.ovf),       32'd1);
        end
        @(posedge clk);
        #1 if8.in_valid = 1'b0; if8.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_released_out_valid", 32'(if8.out_valid), 32'd0);
        check("bp_released_in_ready",  32'(if8.in_ready),  32'd1);
        check("bp_nothing_queued",     32'(sb8.size()),    32'd0);

        // Reset between E3 and E4 of an in-flight operation.
        if8.a = 8'h35; if8.b = 8'h4A; if8.cin = 1'b0; if8.in_valid = 1'b1;
        @(posedge clk);
        #1 if8.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(if8.out_valid), 32'd0);
        check("midrst_sum",       32'(if8.sum),       32'd0);
        check("midrst_cout",      32'(if8.cout),      32'd0);
        check("midrst_ovf",       32'(if8.ovf),       32'd0);
        check("midrst_in_ready",  32'(if8.in_ready),  32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op8(8'h12, 8'h34, 1'b0, res8_t'({8'h46, 1'b0, 1'b0}));
        @(negedge clk);

        // WIDTH=1 instance: full-adder truth table.
        for (int i = 0; i < 8; i++) begin
            xa  = 1'(i >> 2);
            xb  = 1'(i >> 1);
            xc  = 1'(i);
            xs  = xa ^ xb ^ xc;
            xco = (xa & xb) | (xa & xc) | (xb & xc);
            op1(xa, xb, xc, res1_t'({xs, xco, xc ^ xco}));
        end
        @(negedge clk);
        @(negedge clk);

        check("w8_scoreboard_empty", 32'(sb8.size()), 32'd0);
        check("w1_scoreboard_empty", 32'(sb1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
